id_hazard_ctrl: RTL and testbench
=================================

Name: id_hazard_ctrl

Overview:
- Decode-stage hazard and issue controller. It sits directly upstream of the ID/EX pipeline register and decides each cycle whether the decoded instruction is issued into ID/EX, replaced by a bubble (nop), or killed.
- Keeps a small scoreboard of in-flight destination registers to detect RAW hazards.
- Applies branch/jump flushes from EX.
- Sequences processor halt: issue, drain, then stop.

Parameters:
- DEPTH, 3, number of in-flight slots tracked (EX, MEM, WB); legal values 1..4.
- FORWARDING, 0. When 0, stall on any scoreboard match. When 1, stall only on load-use (match in the EX slot whose entry is a load).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- valid_id  in  1  ID holds a real instruction
- r1Num_id  in  3  source register 1 number
- r2Num_id  in  3  source register 2 number
- r1Used_id  in  1  source 1 is read
- r2Used_id  in  1  source 2 is read
- regWriteEnable_id  in  1  instruction writes a register
- regWriteNum_id  in  3  destination register
- memReadEnable_id  in  1  instruction is a load
- halt_id  in  1  instruction is HALT
- flush_ex  in  1  branch/jump taken, resolved in EX this cycle
- mem_stall  in  1  data memory busy; freeze whole pipe
- stall_ifid  out  1  hold PC and IF/ID contents
- flush_ifid  out  1  invalidate IF/ID next edge
- bubble_idex  out  1  force all ID/EX control inputs to zero (nop)
- hold_idex  out  1  ID/EX must keep its current contents
- issue  out  1  ID instruction enters ID/EX at next edge
- halt_issue  out  1  drive ID/EX halt_in
- halted  out  1  pipeline drained after HALT (registered)
- pending  out  3  count of valid scoreboard slots

Behaviour:
- Reset (async, immediate):
  - All scoreboard slots invalid; state RUN; drain counter 0; halted 0; pending 0.
  - Combinational outputs then resolve to stall_ifid=0, flush_ifid=0, hold_idex=0.
  - bubble_idex=1 and issue=0 while valid_id=0.
- Scoreboard:
  - Slot[i] = {v, regnum, isload}; slot 0 is EX, slot DEPTH-1 is the oldest.
  - On every edge with mem_stall=0: slot[i+1] <= slot[i] and slot[0] <= {issue & regWriteEnable_id, regWriteNum_id, memReadEnable_id}.
  - On an edge with mem_stall=1: all slots hold.
- Hazard:
  - match_k = v[k] & (r1Used_id & r1Num_id==regnum[k] | r2Used_id & r2Num_id==regnum[k]).
  - FORWARDING=0: hz = OR over all k of match_k.
  - FORWARDING=1: hz = match_0 & isload[0].
  - Register R0 is not special; a match on R0 still stalls.
- Priority, evaluated combinationally each cycle:
  1. mem_stall=1: stall_ifid=1, hold_idex=1, bubble_idex=0, issue=0, flush_ifid=0. No state changes.
  2. flush_ex=1: flush_ifid=1, bubble_idex=1, issue=0, stall_ifid=0.
  3. state != RUN: stall_ifid=1, bubble_idex=1, issue=0.
  4. valid_id & hz: stall_ifid=1, bubble_idex=1, issue=0.
  5. Otherwise: issue=valid_id, bubble_idex=~valid_id.
- halt_issue = issue & halt_id.
- Halt FSM:
  - RUN -> DRAIN on an edge where halt_issue=1. The drain counter loads DEPTH+1.
  - DRAIN: counter decrements on each edge with mem_stall=0.
  - DRAIN -> RUN if flush_ex=1 (an older taken branch kills the HALT). The counter clears.
  - DRAIN -> HALTED when the counter reaches 0 with mem_stall=0.
  - HALTED: halted=1; stall_ifid=1, bubble_idex=1 permanently. Only rst leaves HALTED.
  - flush_ex in HALTED is ignored.
- Latency:
  - A stall clears on the first cycle no valid slot matches.
  - FORWARDING=0, dependent back-to-back pair: exactly DEPTH bubble cycles.
- pending = popcount of slot v bits, registered alongside the slots.
- A simultaneous flush_ex and hazard yields flush, not stall.
- A simultaneous mem_stall and flush_ex yields freeze. The flush is re-presented by EX, which is frozen.

Decomposition:
- Shared package holds:
  - constants REG_NUM_W=3 and STATE_RUN/STATE_DRAIN/STATE_HALTED (2-bit encoding);
  - the scoreboard-slot record layout.
- One natural sub-module: id_scoreboard (shift-register slots, match vector, pending count). Hazard priority and the halt FSM stay in the top.

Test Plan:
- FORWARDING=0, DEPTH=3:
  - Issue ADD r3; next cycle SUB reads r3 -> stall_ifid=1, bubble_idex=1 for exactly 3 cycles, then issue=1 on cycle 4. pending goes 1,1,1,0.
- FORWARDING=1:
  - LD r2 then ADD reads r2 -> one bubble cycle.
  - ADD r2 then ADD reads r2 -> zero bubbles.
- Hazard stall active, flush_ex pulsed -> same cycle flush_ifid=1, stall_ifid=0, issue=0. The scoreboard shifts in an invalid slot.
- mem_stall held 4 cycles during a hazard stall -> hold_idex=1, pending unchanged. The stall resumes with the same remaining count once mem_stall drops.
- HALT issued, DEPTH=3 -> halt_issue=1 one cycle; DRAIN 4 cycles; halted=1 on cycle 5. Variant: flush_ex in the 2nd DRAIN cycle -> back to RUN, halted stays 0.
- Assert rst mid-DRAIN with 2 pending slots -> immediately pending=0, halted=0, state RUN. The first instruction after release issues without stall.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the decode-stage hazard/issue controller: register-number width,
// halt FSM state encoding and the in-flight scoreboard slot record.
package id_hazard_ctrl_pkg;

  localparam int REG_NUM_W = 3;

  typedef enum logic [1:0] {
    STATE_RUN    = 2'd0,
    STATE_DRAIN  = 2'd1,
    STATE_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic                 v;
    logic [REG_NUM_W-1:0] regnum;
    logic                 isload;
  } sb_slot_t;

  // True when a valid slot's destination is read by either source operand.
  function automatic logic slot_hit(sb_slot_t s,
                                    logic [REG_NUM_W-1:0] r1, logic u1,
                                    logic [REG_NUM_W-1:0] r2, logic u2);
    return s.v & ((u1 & (r1 == s.regnum)) | (u2 & (r2 == s.regnum)));
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage handshake bundle: instruction fields from ID, EX/memory events,
// and the issue/stall/flush controls returned to the pipeline registers.
interface id_hazard_ctrl_if;
  import id_hazard_ctrl_pkg::*;

  logic                 valid_id;
  logic [REG_NUM_W-1:0] r1Num_id;
  logic [REG_NUM_W-1:0] r2Num_id;
  logic                 r1Used_id;
  logic                 r2Used_id;
  logic                 regWriteEnable_id;
  logic [REG_NUM_W-1:0] regWriteNum_id;
  logic                 memReadEnable_id;
  logic                 halt_id;
  logic                 flush_ex;
  logic                 mem_stall;

  logic                 stall_ifid;
  logic                 flush_ifid;
  logic                 bubble_idex;
  logic                 hold_idex;
  logic                 issue;
  logic                 halt_issue;
  logic                 halted;
  logic [2:0]           pending;

  modport master (
    output valid_id, r1Num_id, r2Num_id, r1Used_id, r2Used_id,
           regWriteEnable_id, regWriteNum_id, memReadEnable_id, halt_id,
           flush_ex, mem_stall,
    input  stall_ifid, flush_ifid, bubble_idex, hold_idex, issue,
           halt_issue, halted, pending
  );

  modport slave (
    input  valid_id, r1Num_id, r2Num_id, r1Used_id, r2Used_id,
           regWriteEnable_id, regWriteNum_id, memReadEnable_id, halt_id,
           flush_ex, mem_stall,
    output stall_ifid, flush_ifid, bubble_idex, hold_idex, issue,
           halt_issue, halted, pending
  );
endinterface

// File: rtl/id_hazard_ctrl_scoreboard.sv
// In-flight destination scoreboard: one slot per downstream stage, shifted each
// unfrozen edge; reports per-slot source matches and a registered valid count.
module id_scoreboard
  import id_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  sb_slot_t             new_slot,
  input  logic [REG_NUM_W-1:0] r1_num,
  input  logic                 r1_used,
  input  logic [REG_NUM_W-1:0] r2_num,
  input  logic                 r2_used,
  output logic [DEPTH-1:0]     match,
  output logic                 load_ex,
  output logic [2:0]           pending
);

  sb_slot_t [DEPTH-1:0] slots;
  sb_slot_t [DEPTH-1:0] slots_nxt;
  logic     [2:0]       pending_nxt;

  always_comb begin
    slots_nxt = slots;
    if (shift_en) begin
      slots_nxt[0] = new_slot;
      for (int i = 1; i < DEPTH; i++) slots_nxt[i] = slots[i-1];
    end
  end

  // Count is taken from the next-state slots so it registers alongside them.
  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < DEPTH; i++) pending_nxt = pending_nxt + {2'b00, slots_nxt[i].v};
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) match[i] = slot_hit(slots[i], r1_num, r1_used, r2_num, r2_used);
  end

  assign load_ex = slots[0].isload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots   <= '0;
      pending <= '0;
    end else begin
      slots   <= slots_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard and issue controller: RAW stall, EX flush, memory freeze and
// the HALT issue/drain/stop sequence, driving the IF/ID and ID/EX controls.
//
//   state        | meaning
//   STATE_RUN    | normal issue; hazards and flushes evaluated
//   STATE_DRAIN  | HALT issued; counting older instructions out of the pipe
//   STATE_HALTED | pipe drained; fetch and issue blocked until reset
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int FORWARDING = 0
) (
  input logic             clk,
  input logic             rst,
  id_hazard_ctrl_if.slave bus
);

  localparam logic [2:0] DRAIN_LOAD = 3'(DEPTH + 1);

  state_e           state, state_nxt;
  logic [2:0]       drain_cnt, drain_cnt_nxt;
  logic [DEPTH-1:0] match;
  logic             load_ex;
  logic             hz;
  logic             issue_c;
  sb_slot_t         new_slot;

  id_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .shift_en (~bus.mem_stall),
    .new_slot (new_slot),
    .r1_num   (bus.r1Num_id),
    .r1_used  (bus.r1Used_id),
    .r2_num   (bus.r2Num_id),
    .r2_used  (bus.r2Used_id),
    .match    (match),
    .load_ex  (load_ex),
    .pending  (bus.pending)
  );

  assign hz = (FORWARDING != 0) ? (match[0] & load_ex) : (|match);

  assign new_slot = '{v:      issue_c & bus.regWriteEnable_id,
                      regnum: bus.regWriteNum_id,
                      isload: bus.memReadEnable_id};

  // HALTED outranks everything, including freeze, so fetch stays blocked for good.
  always_comb begin
    bus.stall_ifid  = 1'b0;
    bus.flush_ifid  = 1'b0;
    bus.bubble_idex = 1'b0;
    bus.hold_idex   = 1'b0;
    issue_c         = 1'b0;
    if (state == STATE_HALTED) begin
      bus.stall_ifid  = 1'b1;
      bus.bubble_idex = 1'b1;
    end else if (bus.mem_stall) begin
      bus.stall_ifid  = 1'b1;
      bus.hold_idex   = 1'b1;
    end else if (bus.flush_ex) begin
      bus.flush_ifid  = 1'b1;
      bus.bubble_idex = 1'b1;
    end else if (state != STATE_RUN) begin
      bus.stall_ifid  = 1'b1;
      bus.bubble_idex = 1'b1;
    end else if (bus.valid_id && hz) begin
      bus.stall_ifid  = 1'b1;
      bus.bubble_idex = 1'b1;
    end else begin
      issue_c         = bus.valid_id;
      bus.bubble_idex = ~bus.valid_id;
    end
  end

  assign bus.issue      = issue_c;
  assign bus.halt_issue = issue_c & bus.halt_id;
  assign bus.halted     = (state == STATE_HALTED);

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    if (!bus.mem_stall) begin
      unique case (state)
        STATE_RUN: begin
          if (bus.halt_issue) begin
            state_nxt     = STATE_DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
          end
        end
        STATE_DRAIN: begin
          if (bus.flush_ex) begin
            state_nxt     = STATE_RUN;
            drain_cnt_nxt = '0;
          end else if (drain_cnt <= 3'd1) begin
            state_nxt     = STATE_HALTED;
            drain_cnt_nxt = '0;
          end else begin
            drain_cnt_nxt = drain_cnt - 3'd1;
          end
        end
        STATE_HALTED: ;
        default: begin
          state_nxt     = STATE_RUN;
          drain_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STATE_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Scoreboarded bench: two controllers (no forwarding / load-use forwarding) share
// one stimulus stream and are checked each cycle against an in-flight-list model.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       i_v, i_r1u, i_r2u, i_we, i_ld, i_h, i_fx, i_ms;
  logic [2:0] i_r1, i_r2, i_wn;

  id_hazard_ctrl_if bus0 ();
  id_hazard_ctrl_if bus1 ();

  assign bus0.valid_id = i_v;           assign bus1.valid_id = i_v;
  assign bus0.r1Num_id = i_r1;          assign bus1.r1Num_id = i_r1;
  assign bus0.r2Num_id = i_r2;          assign bus1.r2Num_id = i_r2;
  assign bus0.r1Used_id = i_r1u;        assign bus1.r1Used_id = i_r1u;
  assign bus0.r2Used_id = i_r2u;        assign bus1.r2Used_id = i_r2u;
  assign bus0.regWriteEnable_id = i_we; assign bus1.regWriteEnable_id = i_we;
  assign bus0.regWriteNum_id = i_wn;    assign bus1.regWriteNum_id = i_wn;
  assign bus0.memReadEnable_id = i_ld;  assign bus1.memReadEnable_id = i_ld;
  assign bus0.halt_id = i_h;            assign bus1.halt_id = i_h;
  assign bus0.flush_ex = i_fx;          assign bus1.flush_ex = i_fx;
  assign bus0.mem_stall = i_ms;         assign bus1.mem_stall = i_ms;

  id_hazard_ctrl #(.DEPTH(DEPTH), .FORWARDING(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  id_hazard_ctrl #(.DEPTH(DEPTH), .FORWARDING(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Vector layout: [9]stall_ifid [8]flush_ifid [7]bubble_idex [6]hold_idex
  // [5]issue [4]halt_issue [3]halted [2:0]pending
  wire [9:0] act0 = {bus0.stall_ifid, bus0.flush_ifid, bus0.bubble_idex, bus0.hold_idex,
                     bus0.issue, bus0.halt_issue, bus0.halted, bus0.pending};
  wire [9:0] act1 = {bus1.stall_ifid, bus1.flush_ifid, bus1.bubble_idex, bus1.hold_idex,
                     bus1.issue, bus1.halt_issue, bus1.halted, bus1.pending};

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [9:0] act, logic [9:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_int(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each in-flight writer is an entry with an age in stages past ID (0 = in EX).
  typedef struct { int u; int rg; bit ld; int age; } inflight_t;
  inflight_t fl[$];
  int mode[2];      // 0 run, 1 draining, 2 halted
  int left[2];      // drain cycles still to go

  function automatic logic [9:0] model_out(int u);
    bit hz = 0; int pend = 0;
    bit st = 0, fo = 0, bb = 0, hd = 0, is = 0;
    foreach (fl[i]) if (fl[i].u == u) begin
      bit m = (i_r1u && int'(i_r1) == fl[i].rg) || (i_r2u && int'(i_r2) == fl[i].rg);
      pend++;
      if (u == 0 ? m : (m && fl[i].age == 0 && fl[i].ld)) hz = 1;
    end
    if (mode[u] == 2)           begin st = 1; bb = 1; end
    else if (i_ms)              begin st = 1; hd = 1; end
    else if (i_fx)              begin fo = 1; bb = 1; end
    else if (mode[u] != 0)      begin st = 1; bb = 1; end
    else if (i_v && hz)         begin st = 1; bb = 1; end
    else                        begin is = i_v; bb = !i_v; end
    return {st, fo, bb, hd, is, is && i_h, mode[u] == 2, 3'(pend)};
  endfunction

  function automatic void advance(int u, logic [9:0] e);
    inflight_t keep[$];
    inflight_t t;
    if (i_ms) return;
    if (mode[u] == 1) begin
      if (i_fx) mode[u] = 0;
      else begin
        left[u]--;
        if (left[u] == 0) mode[u] = 2;
      end
    end else if (mode[u] == 0 && e[4]) begin
      mode[u] = 1;
      left[u] = DEPTH + 1;
    end
    foreach (fl[i]) begin
      if (fl[i].u != u) keep.push_back(fl[i]);
      else if (fl[i].age + 1 < DEPTH) begin
        t = fl[i]; t.age++; keep.push_back(t);
      end
    end
    if (e[5] && i_we) begin
      t.u = u; t.rg = int'(i_wn); t.ld = i_ld; t.age = 0;
      keep.push_back(t);
    end
    fl = keep;
  endfunction

  // ---------------- scoreboard queue + monitor ----------------
  typedef struct { logic [9:0] e0; logic [9:0] e1; } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dut_fwd0", act0, e.e0);
      chk("dut_fwd1", act1, e.e1);
    end
  end

  logic [9:0] s0, s1;   // DUT outputs sampled at the last negedge, for directed counts

  task automatic drive(bit v, int a, bit au, int b, bit bu, bit w, int wn, bit l, bit h,
                       bit f, bit m);
    i_v = v; i_r1 = 3'(a); i_r1u = au; i_r2 = 3'(b); i_r2u = bu;
    i_we = w; i_wn = 3'(wn); i_ld = l; i_h = h; i_fx = f; i_ms = m;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at posedge+1 with inputs already driven: queue expectations, run one cycle.
  task automatic step();
    exp_t e;
    e.e0 = model_out(0);
    e.e1 = model_out(1);
    exp_q.push_back(e);
    @(negedge clk);
    s0 = act0; s1 = act1;
    @(posedge clk);
    advance(0, e.e0);
    advance(1, e.e1);
    #1;
  endtask

  task automatic idle_steps(int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    chk("reset_fwd0", act0, 10'b0010000000);
    chk("reset_fwd1", act1, 10'b0010000000);
    rst = 1'b0;
    fl.delete();
    mode[0] = 0; mode[1] = 0; left[0] = 0; left[1] = 0;
    #1;
  endtask

  int  n;
  bit  got;

  initial begin
    idle();
    mode[0] = 0; mode[1] = 0; left[0] = 0; left[1] = 0;
    @(posedge clk); #1;
    do_reset();
    idle_steps(2);

    // Dependent pair without forwarding: DEPTH bubbles, then issue.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0); step();
    drive(1, 3, 1, 4, 0, 1, 4, 0, 0, 0, 0);
    n = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (s0[5]) got = 1; else if (s0[9]) n++;
    end
    chk_int("fwd0_pair_issued", int'(got), 1);
    chk_int("fwd0_pair_bubbles", n, DEPTH);
    idle_steps(4);

    // Forwarding: load-use costs one bubble.
    drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0); step();
    drive(1, 2, 1, 0, 0, 1, 5, 0, 0, 0, 0);
    n = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (s1[5]) got = 1; else if (s1[9]) n++;
    end
    chk_int("fwd1_loaduse_bubbles", n, 1);
    idle_steps(4);

    // Forwarding: ALU result feeds next instruction with no bubble.
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0); step();
    drive(1, 0, 0, 2, 1, 1, 6, 0, 0, 0, 0);
    n = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (s1[5]) got = 1; else if (s1[9]) n++;
    end
    chk_int("fwd1_alu_bubbles", n, 0);
    idle_steps(4);

    // Flush wins over an active hazard stall.
    drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0); step();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0); step();
    chk_int("flush_over_stall", int'(s0[9:5]), int'(5'b01100));
    idle_steps(4);

    // Freeze during a hazard stall keeps the remaining stall count.
    drive(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0); step();
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step();
    drive(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (s0[5]) got = 1; else if (s0[9]) n++;
    end
    chk_int("mstall_resume_bubbles", n, DEPTH - 1);
    idle_steps(4);

    // HALT killed by a flush in the second drain cycle.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    idle(); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    idle_steps(7);
    chk_int("halt_killed_not_halted", int'(s0[3]), 0);

    // Randomized traffic (no HALT).
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 9) < 7,
            $urandom_range(0, 3), $urandom_range(0, 9) < 3, 0,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15);
      step();
    end
    idle_steps(5);

    // Reset mid-drain with two writers in flight.
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    chk_int("pending_mid_drain", int'(bus0.pending), 2);
    do_reset();
    drive(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0); step();
    chk_int("issue_after_reset", int'(s0[5]), 1);
    idle_steps(3);

    // Full HALT: halted appears DEPTH+2 cycles after the HALT issue cycle.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    chk_int("halt_issue_pulse", int'(s0[4]), 1);
    idle();
    n = 0; got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      n++;
      if (s0[3]) got = 1;
    end
    chk_int("halt_latency", n, DEPTH + 2);

    // Flushes and instructions are ignored once halted.
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 0, 0, 0, 1, 1, 0, 0, $urandom_range(0, 1), 0);
      step();
    end
    idle_steps(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
